ula_seq: RTL and testbench

- Multi-cycle execution unit that consumes the 4-bit ALUControl code produced by the ALU control decoder, together with the operands, and returns a registered result.
- Logical, arithmetic, compare and LUI codes complete in one cycle.
- SLL, SRL and SRA are performed iteratively, one bit per cycle, so no barrel shifter is needed.
- Sits in the EX stage between the operand muxes and the writeback register, behind a valid/ready handshake on both sides.

---
 rtl/ula_seq.sv | 123 ++++++++++++
 tb/tb_ula_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - multi-cycle EX-stage ALU with bit-serial shifts
// Single-cycle logic/arith/compare/LUI; SLL/SRL/SRA shift one bit per cycle.
module ula_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  logic [1:0]       sop;
  logic             zero_q;
  logic             ovf_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             is_shift;
  logic [WIDTH-1:0] shift_next;

  assign sum      = op_a + op_b;
  assign diff     = op_a - op_b;
  assign is_shift = (ALUControl[3:2] == 2'b10) && (ALUControl[1:0] != 2'b11);

  always_comb begin
    alu_res = sum;
    alu_ovf = 1'b0;
    case (ALUControl)
      4'b0001: begin
        alu_res = diff;
        alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      4'b0010: alu_res = op_a & op_b;
      4'b0011: alu_res = op_a | op_b;
      4'b0100: alu_res = op_a ^ op_b;
      4'b0101: alu_res = ~(op_a | op_b);
      4'b0110: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b0111: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      // Shift by zero completes immediately with the unshifted operand
      4'b1000, 4'b1001, 4'b1010: alu_res = op_b;
      4'b1011: alu_res = {op_b[15:0], {(WIDTH-16){1'b0}}};
      default: begin
        alu_res = sum;
        alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
    endcase
  end

  always_comb begin
    case (sop)
      2'b00:   shift_next = {acc[WIDTH-2:0], 1'b0};
      2'b01:   shift_next = {1'b0, acc[WIDTH-1:1]};
      default: shift_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      sop    <= 2'b00;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_shift && (shamt != '0)) begin
              acc    <= op_b;
              cnt    <= shamt;
              sop    <= ALUControl[1:0];
              zero_q <= 1'b0;
              ovf_q  <= 1'b0;
              state  <= SHIFT;
            end else begin
              acc    <= alu_res;
              zero_q <= (alu_res == '0);
              ovf_q  <= alu_ovf;
              state  <= DONE;
            end
          end
        end
        SHIFT: begin
          acc <= shift_next;
          cnt <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            zero_q <= (shift_next == '0);
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = acc;
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ula_seq.sv
// tb/tb_ula_seq.sv - self-checking bench for ula_seq
// Directed test-plan steps followed by random operations against a reference model.
module tb_ula_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ALUControl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  ula_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .op_a(op_a), .op_b(op_b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {overflow, result} from plain signed/unsigned arithmetic
  function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] s);
    longint      r;
    logic [31:0] res;
    logic        ov;
    ov = 1'b0;
    case (c)
      4'd1: begin
        r   = longint'($signed(a)) - longint'($signed(b));
        res = a - b;
        ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = a ^ b;
      4'd5:  res = ~(a | b);
      4'd6:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7:  res = (a < b) ? 32'd1 : 32'd0;
      4'd8:  res = b << s;
      4'd9:  res = b >> s;
      4'd10: res = $signed(b) >>> s;
      4'd11: res = {b[15:0], 16'h0000};
      default: begin
        r   = longint'($signed(a)) + longint'($signed(b));
        res = a + b;
        ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
    endcase
    return {ov, res};
  endfunction

  task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] s);
    logic [32:0] exp;
    int          lat;
    int          exp_lat;
    exp     = model(c, a, b, s);
    exp_lat = ((c >= 4'd8) && (c <= 4'd10) && (s != 5'd0)) ? int'(s) + 1 : 1;
    @(negedge clk);
    ALUControl = c; op_a = a; op_b = b; shamt = s; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ALUControl = 4'($urandom); op_a = $urandom; op_b = $urandom; shamt = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".res"}, 64'(result), 64'(exp[31:0]));
    chk({tag, ".zero"}, 64'(zero), 64'(exp[31:0] == 32'd0));
    chk({tag, ".ovf"}, 64'(overflow), 64'(exp[32]));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [3:0] rc;
    logic [4:0] rs;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    ALUControl = 4'd0; op_a = '0; op_b = '0; shamt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.result", 64'(result), 64'd0);

    run_op("add_ovf", 4'd0, 32'h7FFFFFFF, 32'h1, 5'd0);
    chk("add_ovf.lit_res", 64'(model(4'd0, 32'h7FFFFFFF, 32'h1, 5'd0)), 64'h1_8000_0000);
    run_op("sub_zero", 4'd1, 32'd5, 32'd5, 5'd0);
    run_op("slt", 4'd6, 32'hFFFFFFFF, 32'h1, 5'd0);
    run_op("sltu", 4'd7, 32'hFFFFFFFF, 32'h1, 5'd0);
    run_op("sra31", 4'd10, 32'hFFFF0000, 32'h80000000, 5'd31);
    run_op("srl31", 4'd9, 32'h0, 32'h80000000, 5'd31);
    run_op("sll0", 4'd8, 32'h0, 32'h1, 5'd0);
    run_op("lui", 4'd11, 32'h0, 32'h00001234, 5'd0);
    run_op("code15", 4'd15, 32'd2, 32'd3, 5'd0);

    // Backpressure: hold out_ready low while a second request waits
    @(negedge clk);
    ALUControl = 4'd4; op_a = 32'h0000F0F0; op_b = 32'h00000FF0; shamt = 5'd0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    ALUControl = 4'd0; op_a = 32'd10; op_b = 32'd20;
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", 64'(out_valid), 64'd1);
      chk("bp.result", 64'(result), 64'h0000FF00);
      chk("bp.in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp.back_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp.pending_valid", 64'(out_valid), 64'd1);
    chk("bp.pending_res", 64'(result), 64'd30);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a long shift
    @(negedge clk);
    ALUControl = 4'd8; op_a = 32'h0; op_b = 32'h1; shamt = 5'd20; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst.result", 64'(result), 64'd0);
    chk("mid_rst.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_add", 4'd0, 32'd1, 32'd1, 5'd0);

    // Random operations, shift amounts kept small to bound run time
    for (int n = 0; n < 40; n++) begin
      rc = 4'($urandom);
      rs = 5'($urandom_range(0, 12));
      run_op($sformatf("rnd%0d_c%0d", n, rc), rc, $urandom, $urandom, rs);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
